// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: boot-time loader between the UART RX byte stream and the
// ICCM write port. Bytes are packed little-endian into 32-bit words. Each word
// is written at BASE_ADDR + 4*n. The end-of-program marker releases the core
// from reset. The core is held in reset for the whole load, so it never
// fetches from a partially written ICCM.
//
// Write port handshake: mem_req_o is raised the cycle after a word completes.
// mem_addr_o, mem_wdata_o and mem_be_o stay stable while mem_req_o is high.
// A transfer happens on every rising clk_i where mem_req_o && mem_gnt_i. After
// that, mem_req_o drops in the next cycle. The request is never withdrawn
// except by overrun, restart_i or rst_ni.
module prog_load_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [31:0] EOP_WORD = 32'h0000_0FFF,
  parameter int unsigned MAX_WORDS = 1024,
  localparam int unsigned CNT_W = $clog2(MAX_WORDS) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_byte_i,
  input  logic                  restart_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_be_o,
  input  logic                  mem_gnt_i,
  output logic                  core_rst_no,
  output logic                  load_done_o,
  output logic                  err_o,
  output logic [CNT_W-1:0]      word_count_o,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    ST_RECV  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [23:0]      byte_buf_q, byte_buf_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             core_rst_n_q;

  logic             byte_accept;
  logic             word_done;
  logic [31:0]      full_word;
  logic [ADDR_WIDTH-1:0] addr_sum;

  // A restart cycle discards any byte arriving with it.
  assign byte_accept = rx_valid_i && !restart_i &&
                       ((state_q == ST_RECV) || (state_q == ST_WRITE));
  assign word_done   = byte_accept && (byte_idx_q == 2'd3);
  assign full_word   = {rx_byte_i, byte_buf_q};

  // Next-state, byte assembly and word counting.
  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    byte_buf_d   = byte_buf_q;
    word_count_d = word_count_q;
    wdata_d      = wdata_q;

    if (restart_i) begin
      state_d      = ST_RECV;
      byte_idx_d   = 2'd0;
      word_count_d = '0;
    end else begin
      if (byte_accept) begin
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q != 2'd3) begin
          byte_buf_d[8*byte_idx_q +: 8] = rx_byte_i;
        end
      end

      case (state_q)
        ST_RECV: begin
          if (word_done) begin
            if (full_word == EOP_WORD) begin
              state_d = ST_DONE;
            end else if (word_count_q == CNT_W'(MAX_WORDS)) begin
              state_d = ST_ERROR;
            end else begin
              wdata_d = full_word;
              state_d = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          // A grant in the overrun cycle still counts as a completed write.
          if (mem_gnt_i) begin
            word_count_d = word_count_q + CNT_W'(1);
          end
          if (word_done) begin
            state_d = ST_ERROR;
          end else if (mem_gnt_i) begin
            state_d = ST_RECV;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and datapath registers; core reset release is a plain flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RECV;
      byte_idx_q   <= 2'd0;
      byte_buf_q   <= '0;
      word_count_q <= '0;
      wdata_q      <= '0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      byte_buf_q   <= byte_buf_d;
      word_count_q <= word_count_d;
      wdata_q      <= wdata_d;
      core_rst_n_q <= (state_d == ST_DONE);
    end
  end

  // The address follows the word count, so it needs no separate register.
  assign addr_sum     = BASE_ADDR + (ADDR_WIDTH'(word_count_q) << 2);
  assign mem_addr_o   = {addr_sum[ADDR_WIDTH-1:2], 2'b00};
  assign mem_req_o    = (state_q == ST_WRITE);
  assign mem_we_o     = mem_req_o;
  assign mem_be_o     = mem_req_o ? 4'hF : 4'h0;
  assign mem_wdata_o  = wdata_q;
  assign core_rst_no  = core_rst_n_q;
  assign load_done_o  = (state_q == ST_DONE);
  assign err_o        = (state_q == ST_ERROR);
  assign word_count_o = word_count_q;
  assign dbg_state_o  = state_q;

endmodule
